regfile_wr_sched: RTL

Write-port scheduler and pending-write scoreboard for the 32×32 general register file. Merges the in-order writeback stream with results from slow out-of-pipeline units (divider, uncached load return) onto the single register-file write port. Tracks registers that have an outstanding slow write and tells ID to stall on reads of them. Sits between WB and the register file, beside ID.

---
 rtl/regfile_wr_sched_pkg.sv | 8 +
 rtl/regfile_wr_sched_rr_arbiter.sv | 41 ++++
 rtl/regfile_wr_sched.sv | 105 ++++++++++
 3 files changed

// File: rtl/regfile_wr_sched_pkg.sv
// rtl/regfile_wr_sched_pkg.sv - shared defaults and constants for the register-file write scheduler
package regfile_wr_sched_pkg;
    localparam int AW_DEF     = 5;
    localparam int DW_DEF     = 32;
    localparam int N_SLOW_DEF = 2;
    localparam int REG_ZERO   = 0;
    localparam logic RF_IDLE_WE = 1'b0;
endpackage

// File: rtl/regfile_wr_sched_rr_arbiter.sv
// rtl/regfile_wr_sched_rr_arbiter.sv - N-way round-robin arbiter with block mask, pointer moves past each grant
module regfile_wr_sched_rr_arbiter #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          block,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);
    logic [PW-1:0] rr_q, rr_d;
    logic          found;
    int            idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = rr_q;
        rr_d    = rr_q;
        found   = 1'b0;
        idx     = 0;
        if (!block) begin
            for (int k = 0; k < N; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= N) idx = idx - N;
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_idx  = PW'(idx);
                    rr_d     = (idx == N - 1) ? '0 : PW'(idx + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_q <= '0;
        else     rr_q <= rr_d;
    end
endmodule

// File: rtl/regfile_wr_sched.sv
// rtl/regfile_wr_sched.sv - merges writeback and slow-unit results onto the regfile write port, tracks pending slow writes
module regfile_wr_sched
    import regfile_wr_sched_pkg::*;
#(
    parameter int N_SLOW = N_SLOW_DEF,
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_waddr,
    input  logic [DW-1:0]        wb_wdata,
    input  logic [N_SLOW-1:0]    slow_valid,
    output logic [N_SLOW-1:0]    slow_ready,
    input  logic [N_SLOW*AW-1:0] slow_waddr,
    input  logic [N_SLOW*DW-1:0] slow_wdata,
    input  logic                 claim_valid,
    input  logic [AW-1:0]        claim_addr,
    input  logic [AW-1:0]        raddr_1,
    input  logic [AW-1:0]        raddr_2,
    input  logic                 re_1,
    input  logic                 re_2,
    output logic                 stall,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata
);
    localparam int PW   = (N_SLOW > 1) ? $clog2(N_SLOW) : 1;
    localparam int NREG = 1 << AW;

    logic              wb_eff;
    logic [PW-1:0]     gnt_idx;
    logic              slow_xfer;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_data;
    logic              rf_we_q, rf_we_d;
    logic [AW-1:0]     rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]     rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0]   pend_q, pend_d;

    assign wb_eff = wb_we && (wb_waddr != AW'(REG_ZERO));

    // Holding the arbiter blocked during reset keeps slow_ready low while rst is high.
    regfile_wr_sched_rr_arbiter #(.N(N_SLOW)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .block   (wb_eff || rst),
        .req     (slow_valid),
        .gnt     (slow_ready),
        .gnt_idx (gnt_idx)
    );

    assign slow_xfer = |slow_ready;
    assign sel_addr  = slow_waddr[int'(gnt_idx)*AW +: AW];
    assign sel_data  = slow_wdata[int'(gnt_idx)*DW +: DW];

    // Idle must drive address 0: the regfile bypass matches on waddr alone.
    always_comb begin
        rf_we_d    = RF_IDLE_WE;
        rf_waddr_d = '0;
        rf_wdata_d = '0;
        if (wb_eff) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_waddr;
            rf_wdata_d = wb_wdata;
        end else if (slow_xfer && (sel_addr != AW'(REG_ZERO))) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = sel_addr;
            rf_wdata_d = sel_data;
        end
    end

    // Clear before set so a claim in the same cycle as the returning write wins.
    always_comb begin
        pend_d = pend_q;
        if (slow_xfer && (sel_addr != AW'(REG_ZERO)))
            pend_d[sel_addr] = 1'b0;
        if (claim_valid && (claim_addr != AW'(REG_ZERO)))
            pend_d[claim_addr] = 1'b1;
        pend_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q    <= RF_IDLE_WE;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pend_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pend_q     <= pend_d;
        end
    end

    assign stall = !rst &&
                   ((re_1 && (raddr_1 != AW'(REG_ZERO)) && pend_q[raddr_1]) ||
                    (re_2 && (raddr_2 != AW'(REG_ZERO)) && pend_q[raddr_2]));

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
endmodule
